// File: rtl/data_qmux_pkg.sv
// rtl/data_qmux_pkg.sv - shared opcodes, state enum and source fields for the Q-opcode router
package data_qmux_pkg;

    localparam logic [3:0] OP_NOP       = 4'b0000;
    localparam logic [3:0] OP_ZERO_CD   = 4'b0001;
    localparam logic [3:0] OP_ZERO_AB   = 4'b0010;
    localparam logic [3:0] OP_ZERO_ABCD = 4'b0011;
    localparam logic [3:0] OP_UIO_SPLIT = 4'b0100;
    localparam logic [3:0] OP_UIO_CD    = 4'b0101;
    localparam logic [3:0] OP_UIO_AB    = 4'b0110;
    localparam logic [3:0] OP_UIO_ACBD  = 4'b0111;
    localparam logic [3:0] OP_MN_SPLIT  = 4'b1000;
    localparam logic [3:0] OP_MN_CD     = 4'b1001;
    localparam logic [3:0] OP_MN_AB     = 4'b1010;
    localparam logic [3:0] OP_MN_ACBD   = 4'b1011;
    localparam logic [3:0] OP_STREAM    = 4'b1100;
    localparam logic [3:0] OP_ONES_CD   = 4'b1101;
    localparam logic [3:0] OP_ONES_AB   = 4'b1110;
    localparam logic [3:0] OP_ONES_ABCD = 4'b1111;

    // Upper two opcode bits pick the data source; lower two pick the target pattern.
    localparam logic [1:0] SRC_ZERO = 2'b00;
    localparam logic [1:0] SRC_UIO  = 2'b01;
    localparam logic [1:0] SRC_MN   = 2'b10;
    localparam logic [1:0] SRC_SPEC = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    function automatic logic [1:0] op_src(input logic [3:0] op);
        return op[3:2];
    endfunction

endpackage

// File: rtl/qmux_group_dec.sv
// rtl/qmux_group_dec.sv - next-value decoder for one A/B/C/D quad group
module qmux_group_dec
    import data_qmux_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] uio_h,
    input  logic [DATA_W-1:0] uio_l,
    input  logic [DATA_W-1:0] m,
    input  logic [DATA_W-1:0] n,
    output logic [DATA_W-1:0] a_nxt,
    output logic [DATA_W-1:0] b_nxt,
    output logic [DATA_W-1:0] c_nxt,
    output logic [DATA_W-1:0] d_nxt
);

    logic [1:0]        src;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    // Pick the source pair, then place it according to the target pattern; unnamed registers hold.
    always_comb begin
        src   = op_src(op);
        hi    = '0;
        lo    = '0;
        a_nxt = a;
        b_nxt = b;
        c_nxt = c;
        d_nxt = d;
        case (src)
            SRC_UIO:  begin hi = uio_h; lo = uio_l; end
            SRC_MN:   begin hi = m;     lo = n;     end
            SRC_SPEC: begin hi = '1;    lo = '1;    end
            default:  begin hi = '0;    lo = '0;    end
        endcase
        if (src == SRC_ZERO || src == SRC_SPEC) begin
            // Fill ops: pattern 00 is NOP (zero source) or STREAM (handled by the top).
            case (op[1:0])
                2'b01:   begin c_nxt = hi; d_nxt = hi; end
                2'b10:   begin a_nxt = hi; b_nxt = hi; end
                2'b11:   begin a_nxt = hi; b_nxt = hi; c_nxt = hi; d_nxt = hi; end
                default: ;
            endcase
        end else begin
            case (op[1:0])
                2'b00:   begin a_nxt = hi; b_nxt = hi; c_nxt = lo; d_nxt = lo; end
                2'b01:   begin c_nxt = hi; d_nxt = lo; end
                2'b10:   begin a_nxt = hi; b_nxt = lo; end
                default: begin a_nxt = hi; b_nxt = lo; c_nxt = hi; d_nxt = lo; end
            endcase
        end
    end

endmodule

// File: rtl/data_qmux_seq.sv
// rtl/data_qmux_seq.sv - grouped Q-opcode register router with op handshake and STREAM load
module data_qmux_seq
    import data_qmux_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int NREG   = 4,
    localparam int NGRP   = NREG / 4,
    localparam int GSEL_W = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               op,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [GSEL_W-1:0]        grp_sel,
    input  logic [DATA_W-1:0]        uio_h,
    input  logic [DATA_W-1:0]        uio_l,
    input  logic [DATA_W-1:0]        m,
    input  logic [DATA_W-1:0]        n,
    input  logic                     uio_valid,
    input  logic                     abort,
    output logic [NREG*DATA_W-1:0]   regs_o,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int                NBEAT    = NREG / 2;
    localparam int                CNT_W    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBEAT - 1);
    localparam int                GRP_BITS = 4 * DATA_W;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NREG*DATA_W-1:0]   regs_q, regs_d;
    logic [NREG*DATA_W-1:0]   dec_flat;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     grp_ok;

    // Every group gets a decoder; only the addressed group's result is committed.
    for (genvar g = 0; g < NGRP; g++) begin : g_dec
        qmux_group_dec #(.DATA_W(DATA_W)) u_dec (
            .op    (op),
            .a     (regs_q[(4*g+0)*DATA_W +: DATA_W]),
            .b     (regs_q[(4*g+1)*DATA_W +: DATA_W]),
            .c     (regs_q[(4*g+2)*DATA_W +: DATA_W]),
            .d     (regs_q[(4*g+3)*DATA_W +: DATA_W]),
            .uio_h (uio_h),
            .uio_l (uio_l),
            .m     (m),
            .n     (n),
            .a_nxt (dec_flat[(4*g+0)*DATA_W +: DATA_W]),
            .b_nxt (dec_flat[(4*g+1)*DATA_W +: DATA_W]),
            .c_nxt (dec_flat[(4*g+2)*DATA_W +: DATA_W]),
            .d_nxt (dec_flat[(4*g+3)*DATA_W +: DATA_W])
        );
    end

    assign grp_ok   = ({1'b0, grp_sel} < (GSEL_W + 1)'(NGRP));
    assign op_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_STREAM);
    assign regs_o   = regs_q;
    assign done     = done_q;
    assign err      = err_q;

    // Next-state, beat counter, register-file update and pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (op == OP_STREAM) begin
                        state_d = S_STREAM;
                        cnt_d   = '0;
                    end else if (!grp_ok) begin
                        err_d = 1'b1;
                    end else begin
                        for (int g = 0; g < NGRP; g++) begin
                            if (grp_sel == GSEL_W'(g)) begin
                                regs_d[g*GRP_BITS +: GRP_BITS] = dec_flat[g*GRP_BITS +: GRP_BITS];
                            end
                        end
                    end
                end
            end
            S_STREAM: begin
                // abort outranks a coincident beat, so that beat is dropped.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (uio_valid) begin
                    for (int i = 0; i < NBEAT; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            regs_d[(2*i)*DATA_W   +: DATA_W] = uio_h;
                            regs_d[(2*i+1)*DATA_W +: DATA_W] = uio_l;
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, registers and pulse outputs; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            regs_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
